// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice oscillators.
package synth_pkg;

  // Waveform select encoding shared by every oscillator in the voice path.
  typedef enum logic [1:0] {
    SAW_UP   = 2'd0,
    SAW_DOWN = 2'd1,
    TRIANGLE = 2'd2,
    PULSE    = 2'd3
  } wave_mode_e;

  // Pulse duty threshold width; compared against the top phase bits.
  localparam int DUTY_W = 8;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample mapping; shared by the audio oscillator and LFO.
module wave_shaper
  import synth_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 11
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         mode,
  input  logic [DUTY_W-1:0]  duty,
  output logic [OUT_W-1:0]   sample
);

  logic [OUT_W-1:0]  saw_s;
  logic [OUT_W-1:0]  tri_s;
  logic [DUTY_W-1:0] top_s;
  logic              unused_phase_s;

  // The lowest phase bits only add resolution to the accumulator, not to the output.
  assign unused_phase_s = ^phase;

  assign saw_s = phase[PHASE_W-1 -: OUT_W];
  assign tri_s = phase[PHASE_W-2 -: OUT_W];
  assign top_s = phase[PHASE_W-1 -: DUTY_W];

  // Map the phase to the selected waveform; the triangle folds at the phase MSB.
  always_comb begin
    sample = {OUT_W{1'b0}};
    case (wave_mode_e'(mode))
      SAW_UP:   sample = saw_s;
      SAW_DOWN: sample = ~saw_s;
      TRIANGLE: begin
        if (phase[PHASE_W-1]) begin
          sample = ~tri_s;
        end else begin
          sample = tri_s;
        end
      end
      PULSE: begin
        if (top_s < duty) begin
          sample = {OUT_W{1'b1}};
        end else begin
          sample = {OUT_W{1'b0}};
        end
      end
      default:  sample = {OUT_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/wave_oscillator.sv
// Phase-accumulator oscillator with shadowed controls that only change at a
// waveform cycle boundary (wrap or sync), and a one-clock registered output.
// Requires PHASE_W >= OUT_W+1 and PHASE_W >= 8.
module wave_oscillator
  import synth_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic [PHASE_W-1:0] freq_inc,
  input  logic [1:0]         mode,
  input  logic [DUTY_W-1:0]  duty,
  input  logic               sync,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               wrap
);

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] act_inc_r;
  logic [1:0]         act_mode_r;
  logic [DUTY_W-1:0]  act_duty_r;
  logic               smp_pend_r;
  logic               wrap_pend_r;

  logic [PHASE_W:0]   sum_s;
  logic [PHASE_W-1:0] phase_nxt_s;
  logic               wrap_evt_s;
  logic               load_s;
  logic [OUT_W-1:0]   shape_s;

  // Carry out of the accumulator add marks the natural end of a waveform cycle.
  assign sum_s = {1'b0, phase_r} + {1'b0, act_inc_r};

  // Next phase and cycle-boundary event; sync overrides the increment.
  always_comb begin
    phase_nxt_s = sum_s[PHASE_W-1:0];
    wrap_evt_s  = sum_s[PHASE_W];
    if (sync) begin
      phase_nxt_s = {PHASE_W{1'b0}};
      wrap_evt_s  = 1'b1;
    end else begin
      phase_nxt_s = sum_s[PHASE_W-1:0];
      wrap_evt_s  = sum_s[PHASE_W];
    end
    // A zero increment means idle/start-up, so new controls apply at once.
    load_s = wrap_evt_s | (act_inc_r == {PHASE_W{1'b0}});
  end

  // Advance the phase and reload the shadow controls at a cycle boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r    <= {PHASE_W{1'b0}};
      act_inc_r  <= {PHASE_W{1'b0}};
      act_mode_r <= 2'd0;
      act_duty_r <= {DUTY_W{1'b0}};
    end else if (sample_en) begin
      phase_r <= phase_nxt_s;
      if (load_s) begin
        act_inc_r  <= freq_inc;
        act_mode_r <= mode;
        act_duty_r <= duty;
      end
    end
  end

  // Remember that a sample step happened so the output stage follows one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_pend_r  <= 1'b0;
      wrap_pend_r <= 1'b0;
    end else begin
      smp_pend_r  <= sample_en;
      wrap_pend_r <= sample_en & wrap_evt_s;
    end
  end

  wave_shaper #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shaper (
    .phase  (phase_r),
    .mode   (act_mode_r),
    .duty   (act_duty_r),
    .sample (shape_s)
  );

  // Register the shaped sample with its strobes; out holds between sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= {OUT_W{1'b0}};
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (smp_pend_r) begin
      out       <= shape_s;
      out_valid <= 1'b1;
      wrap      <= wrap_pend_r;
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_oscillator.sv
// Self-checking bench for wave_oscillator at default parameters.
module tb_wave_oscillator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] freq_inc = 16'd0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  duty = 8'd0;
  logic [10:0] out;
  logic        out_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_oscillator #(.PHASE_W(16), .OUT_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .freq_inc  (freq_inc),
    .mode      (mode),
    .duty      (duty),
    .sync      (sync),
    .out       (out),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  typedef struct {
    int unsigned due;
    int unsigned val;
    bit          wr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_phase = 0;
  int unsigned m_inc = 0;
  int unsigned m_mode = 0;
  int unsigned m_duty = 0;
  int unsigned cyc = 0;
  int unsigned hold = 0;

  // Ideal waveform value for a phase in [0, 65536), as plain arithmetic.
  function automatic int unsigned shape(int unsigned p, int unsigned md, int unsigned dt);
    int unsigned t;
    case (md)
      0: return p / 32;
      1: return 2047 - (p / 32);
      2: begin
        t = (p / 16) % 2048;
        if (p < 32768) return t;
        return 2047 - t;
      end
      default: return ((p / 256) < dt) ? 2047 : 0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one expected sample per tick, due two clock counts later.
  initial forever begin : model
    int unsigned np;
    bit          w;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_inc = 0; m_mode = 0; m_duty = 0; hold = 0;
      exp_q.delete();
    end else begin
      if (sample_en) begin
        if (sync) begin
          np = 0; w = 1'b1;
        end else begin
          np = m_phase + m_inc;
          w  = (np >= 65536);
          np = np % 65536;
        end
        if (w || m_inc == 0) begin
          m_inc = freq_inc; m_mode = mode; m_duty = duty;
        end
        m_phase = np;
        exp_q.push_back('{due: cyc + 2, val: shape(np, m_mode, m_duty), wr: w});
      end
      cyc = cyc + 1;
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  initial forever begin : compare
    bit   want;
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("valid", {31'd0, out_valid}, {31'd0, want});
      if (want) begin
        e = exp_q.pop_front();
        chk("out", {21'd0, out}, e.val);
        chk("wrap", {31'd0, wrap}, {31'd0, e.wr});
        hold = e.val;
      end else begin
        chk("out_hold", {21'd0, out}, hold);
        chk("wrap_idle", {31'd0, wrap}, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic lit(string nm, int unsigned o, int unsigned w);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(nm, {21'd0, out}, o);
    chk({nm, "_wrap"}, {31'd0, wrap}, w);
  endtask

  task automatic do_reset();
    step();
    #2;
    rst_n = 1'b0; sample_en = 1'b0; sync = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int nv;
    // Reset state
    step();
    chk("rst_out", {21'd0, out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);

    // Test 1: saw up at 0x0100
    do_reset();
    freq_inc = 16'h0100; mode = 2'd0; duty = 8'd0; sample_en = 1'b1;
    step(); chk("t1_latency", {31'd0, out_valid}, 32'd0);
    step(); lit("t1_s0", 0, 0);
    step(); lit("t1_s1", 8, 0);
    repeat (254) step();
    lit("t1_s255", 2040, 0);
    step(); lit("t1_s256", 0, 1);

    // Test 2: triangle at quarter-cycle steps
    do_reset();
    freq_inc = 16'h4000; mode = 2'd2; sample_en = 1'b1;
    step(); step(); lit("t2_s0", 0, 0);
    step(); lit("t2_s1", 1024, 0);
    step(); lit("t2_s2", 2047, 0);
    step(); lit("t2_s3", 1023, 0);
    step(); lit("t2_s4", 0, 1);

    // Test 3: pulse at half duty, then duty 0
    do_reset();
    freq_inc = 16'h0100; mode = 2'd3; duty = 8'h80; sample_en = 1'b1;
    step(); step(); lit("t3_s0", 2047, 0);
    repeat (127) step();
    lit("t3_s127", 2047, 0);
    step(); lit("t3_s128", 0, 0);
    repeat (127) step();
    lit("t3_s255", 0, 0);
    step(); lit("t3_s256", 2047, 1);
    do_reset();
    duty = 8'h00; sample_en = 1'b1;
    step(); step();
    repeat (300) step();
    lit("t3_duty0", 0, 0);

    // Test 4: deferred mode/frequency change
    do_reset();
    freq_inc = 16'h0100; mode = 2'd0; duty = 8'd0; sample_en = 1'b1;
    step(); step();
    repeat (50) step();
    lit("t4_s50", 400, 0);
    mode = 2'd1; freq_inc = 16'h0200;
    repeat (205) step();
    lit("t4_s255", 2040, 0);
    step(); lit("t4_s256", 2047, 1);
    step(); lit("t4_s257", 2031, 0);
    step(); lit("t4_s258", 2015, 0);

    // Test 5: hard sync at phase 0x5000, then sync without a tick
    do_reset();
    freq_inc = 16'h0100; mode = 2'd0; sample_en = 1'b1;
    step(); step();
    repeat (79) step();
    lit("t5_s79", 632, 0);
    sync = 1'b1; freq_inc = 16'h0400;
    step(); lit("t5_s80", 640, 0);
    sync = 1'b0;
    step(); lit("t5_sync", 0, 1);
    step(); lit("t5_reload", 32, 0);
    sample_en = 1'b0; sync = 1'b1;
    step(); lit("t5_drain", 64, 0);
    step(); chk("t5_idle", {31'd0, out_valid}, 32'd0);
    sync = 1'b0; sample_en = 1'b1;
    step();
    step(); lit("t5_nolatch", 96, 0);

    // Test 6: asynchronous reset between edges, then gapped ticks
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_out", {21'd0, out}, 32'd0);
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_wrap", {31'd0, wrap}, 32'd0);
    step();
    sample_en = 1'b0;
    step();
    rst_n = 1'b1;
    freq_inc = 16'h0100; mode = 2'd0;
    nv = 0;
    for (int i = 0; i < 32; i++) begin
      sample_en = (i % 4 == 0);
      step();
      if (out_valid === 1'b1) nv++;
    end
    chk("t6_tick_count", nv, 32'd8);
    chk("t6_last", {21'd0, out}, 32'd56);

    sample_en = 1'b0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
